// File: rtl/pll_cfg_if.sv
// PLL management-port bundle: write strobe, address, data and the slave stall.
//   master: drives cfg_write/cfg_address/cfg_data, samples cfg_waitrequest
//   slave : samples cfg_write/cfg_address/cfg_data, drives cfg_waitrequest
interface pll_cfg_if;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    logic              cfg_write;
    logic [ADDR_W-1:0] cfg_address;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_waitrequest;

    modport master (
        output cfg_write,
        output cfg_address,
        output cfg_data,
        input  cfg_waitrequest
    );

    modport slave (
        input  cfg_write,
        input  cfg_address,
        input  cfg_data,
        output cfg_waitrequest
    );
endinterface

// File: rtl/pll_reconf_seq.sv
// Reprograms the system PLL with the six-write NTSC/PAL sequence whenever the
// synchronised standard select differs from the last applied standard, waits
// for re-lock with retries, and holds the console in reset while busy.
//   mgmt_clk, mgmt_reset : 50 MHz clock, synchronous active-high reset
//   pal, pll_locked      : asynchronous inputs, 2-flop synchronised
//   cfg                  : management write port (master side)
//   tv_reset, busy       : high in every non-idle state
//   error                : sticky, last sequence exhausted its retries
module pll_reconf_seq #(
    parameter int unsigned SETTLE       = 16,
    parameter int unsigned LOCK_TIMEOUT = 500000,
    parameter int unsigned RETRIES      = 2
) (
    input  logic          mgmt_clk,
    input  logic          mgmt_reset,
    input  logic          pal,
    input  logic          pll_locked,
    pll_cfg_if.master     cfg,
    output logic          tv_reset,
    output logic          busy,
    output logic          error
);
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned TRY_W  = 3;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_SETTLE,
        S_LOCKWAIT
    } state_t;

    state_t             state, state_nxt;
    logic               pal_meta, pal_s;
    logic               lock_meta, lock_s;
    logic               cur_std, cur_std_nxt;
    logic               std_lat, std_lat_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [TRY_W-1:0]   try_cnt, try_cnt_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               err_q, err_nxt;
    logic               wr_q, wr_nxt;
    logic [ADDR_W-1:0]  addr_q, addr_nxt;
    logic [DATA_W-1:0]  data_q, data_nxt;
    logic               busy_q, busy_nxt;

    // Reconfiguration table: register address per step.
    function automatic logic [ADDR_W-1:0] tbl_addr(input logic [IDX_W-1:0] i);
        case (i)
            3'd0:    tbl_addr = 6'd0;
            3'd1:    tbl_addr = 6'd3;
            3'd2:    tbl_addr = 6'd4;
            3'd3:    tbl_addr = 6'd5;
            3'd4:    tbl_addr = 6'd7;
            default: tbl_addr = 6'd2;
        endcase
    endfunction

    // Reconfiguration table: write data per step; C0 and M fraction depend on standard.
    function automatic logic [DATA_W-1:0] tbl_data(input logic [IDX_W-1:0] i, input logic std);
        case (i)
            3'd1:    tbl_data = 32'h0001_0000;
            3'd2:    tbl_data = 32'h0000_0404;
            3'd3:    tbl_data = std ? 32'h0002_0504 : 32'h0000_0505;
            3'd4:    tbl_data = std ? 32'hA3D7_09E8 : 32'h9745_BF27;
            default: tbl_data = 32'h0000_0000;
        endcase
    endfunction

    // Two-flop synchronisers for the asynchronous inputs.
    always_ff @(posedge mgmt_clk) begin
        if (mgmt_reset) begin
            pal_meta  <= 1'b0;
            pal_s     <= 1'b0;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            pal_meta  <= pal;
            pal_s     <= pal_meta;
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // State and datapath registers.
    always_ff @(posedge mgmt_clk) begin
        if (mgmt_reset) begin
            state   <= S_IDLE;
            cur_std <= 1'b0;
            std_lat <= 1'b0;
            idx     <= '0;
            try_cnt <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cur_std <= cur_std_nxt;
            std_lat <= std_lat_nxt;
            idx     <= idx_nxt;
            try_cnt <= try_cnt_nxt;
            cnt     <= cnt_nxt;
            err_q   <= err_nxt;
            wr_q    <= wr_nxt;
            addr_q  <= addr_nxt;
            data_q  <= data_nxt;
            busy_q  <= busy_nxt;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_nxt   = state;
        cur_std_nxt = cur_std;
        std_lat_nxt = std_lat;
        idx_nxt     = idx;
        try_cnt_nxt = try_cnt;
        cnt_nxt     = cnt;
        err_nxt     = err_q;
        addr_nxt    = addr_q;
        data_nxt    = data_q;

        case (state)
            S_IDLE: begin
                if (pal_s != cur_std) begin
                    std_lat_nxt = pal_s;
                    cur_std_nxt = pal_s;
                    idx_nxt     = '0;
                    try_cnt_nxt = '0;
                    err_nxt     = 1'b0;
                    state_nxt   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!cfg.cfg_waitrequest) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (idx == IDX_W'(5)) begin
                    cnt_nxt   = CNT_W'(SETTLE - 1);
                    state_nxt = S_SETTLE;
                end else begin
                    idx_nxt   = IDX_W'(idx + 1'b1);
                    state_nxt = S_WRITE;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    cnt_nxt   = CNT_W'(LOCK_TIMEOUT - 1);
                    state_nxt = S_LOCKWAIT;
                end else begin
                    cnt_nxt = CNT_W'(cnt - 1'b1);
                end
            end
            S_LOCKWAIT: begin
                // Lock takes priority over a simultaneous expiry.
                if (lock_s) begin
                    state_nxt = S_IDLE;
                end else if (cnt == '0) begin
                    if (try_cnt < TRY_W'(RETRIES)) begin
                        try_cnt_nxt = TRY_W'(try_cnt + 1'b1);
                        idx_nxt     = '0;
                        state_nxt   = S_WRITE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = CNT_W'(cnt - 1'b1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        wr_nxt   = (state_nxt == S_WRITE);
        busy_nxt = (state_nxt != S_IDLE);
        // Address/data only change when a write is presented, so they hold while stalled.
        if (state_nxt == S_WRITE) begin
            addr_nxt = tbl_addr(idx_nxt);
            data_nxt = tbl_data(idx_nxt, std_lat_nxt);
        end
    end

    assign cfg.cfg_write   = wr_q;
    assign cfg.cfg_address = addr_q;
    assign cfg.cfg_data    = data_q;
    assign busy            = busy_q;
    assign tv_reset        = busy_q;
    assign error           = err_q;
endmodule

// File: tb/tb_pll_reconf_seq.sv
// Bench for pll_reconf_seq: table of expected writes per standard, hand-written
// corner sequences, and a randomized phase against a transaction-level model.
module tb_pll_reconf_seq;
    localparam int unsigned SETTLE_C  = 16;
    localparam int unsigned TIMEOUT_C = 100;
    localparam int unsigned RETRIES_C = 2;
    localparam int SEQ_LEN = 12 + SETTLE_C + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pal = 1'b0;
    logic pll_locked = 1'b1;
    logic tv_reset, busy, error;

    pll_cfg_if cfg ();

    pll_reconf_seq #(
        .SETTLE(SETTLE_C),
        .LOCK_TIMEOUT(TIMEOUT_C),
        .RETRIES(RETRIES_C)
    ) dut (
        .mgmt_clk(clk),
        .mgmt_reset(rst),
        .pal(pal),
        .pll_locked(pll_locked),
        .cfg(cfg.master),
        .tv_reset(tv_reset),
        .busy(busy),
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] d_ntsc;
        logic [31:0] d_pal;
    } vec_t;

    wr_t   obs_q[$];
    int    wr_hi = 0;
    int    rd_ptr = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    bit    rnd_mode = 1'b0;
    vec_t  tbl[6];

    // Record every accepted write and every cycle the strobe is high.
    always @(posedge clk) begin
        if (!rst) begin
            if (cfg.cfg_write) wr_hi++;
            if (cfg.cfg_write && !cfg.cfg_waitrequest)
                obs_q.push_back('{cfg.cfg_address, cfg.cfg_data});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) cfg.cfg_waitrequest = ($urandom_range(0, 3) == 0);
    endtask

    task automatic wait_busy_low(input int max, output int cyc);
        cyc = 0;
        while (busy && cyc < max) begin
            tick();
            cyc++;
        end
        if (busy) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_write_addr(input logic [5:0] a, input int max);
        int n;
        n = 0;
        while (!(cfg.cfg_write && cfg.cfg_address == a) && n < max) begin
            tick();
            n++;
        end
        check($sformatf("wait_addr%0d", a), 32'(cfg.cfg_write && cfg.cfg_address == a), 32'd1);
    endtask

    // Compare newly accepted writes against nseq full sequences for standard std.
    task automatic check_writes(input logic std, input int nseq, input string name);
        int avail;
        logic [31:0] ed;
        avail = obs_q.size() - rd_ptr;
        check({name, "_count"}, 32'(avail), 32'(6 * nseq));
        for (int s = 0; s < nseq; s++) begin
            for (int i = 0; i < 6; i++) begin
                if (rd_ptr < obs_q.size()) begin
                    ed = std ? tbl[i].d_pal : tbl[i].d_ntsc;
                    check($sformatf("%s_s%0d_i%0d_addr", name, s, i), 32'(obs_q[rd_ptr].addr), 32'(tbl[i].addr));
                    check($sformatf("%s_s%0d_i%0d_data", name, s, i), obs_q[rd_ptr].data, ed);
                    rd_ptr++;
                end
            end
        end
        rd_ptr = obs_q.size();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_wr"},   32'(cfg.cfg_write), 32'd0);
        check({name, "_addr"}, 32'(cfg.cfg_address), 32'd0);
        check({name, "_data"}, cfg.cfg_data, 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_tvr"},  32'(tv_reset), 32'd0);
        check({name, "_err"},  32'(error), 32'd0);
    endtask

    initial begin
        int cyc;
        int wh0;
        int low;
        bit hold_ok;
        logic model_std;
        logic nv;

        tbl[0] = '{6'd0, 32'h0000_0000, 32'h0000_0000};
        tbl[1] = '{6'd3, 32'h0001_0000, 32'h0001_0000};
        tbl[2] = '{6'd4, 32'h0000_0404, 32'h0000_0404};
        tbl[3] = '{6'd5, 32'h0000_0505, 32'h0002_0504};
        tbl[4] = '{6'd7, 32'h9745_BF27, 32'hA3D7_09E8};
        tbl[5] = '{6'd2, 32'h0000_0000, 32'h0000_0000};

        cfg.cfg_waitrequest = 1'b0;

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (5) tick();

        // 1: NTSC -> PAL, no stalls, lock already present
        pal = 1'b1;
        tick(); check("t1_wr_e1", 32'(cfg.cfg_write), 32'd0);
        tick(); check("t1_wr_e2", 32'(cfg.cfg_write), 32'd0);
        tick();
        check("t1_wr_e3", 32'(cfg.cfg_write), 32'd1);
        check("t1_busy_e3", 32'(busy), 32'd1);
        check("t1_tvr_e3", 32'(tv_reset), 32'd1);
        wh0 = wr_hi;
        wait_busy_low(500, cyc);
        check("t1_busy_len", 32'(cyc), 32'(SEQ_LEN));
        check("t1_wr_cycles", 32'(wr_hi - wh0), 32'd6);
        check_writes(1'b1, 1, "t1");
        check("t1_err", 32'(error), 32'd0);

        // 2: stall write idx 2 for 5 cycles during a PAL -> NTSC sequence
        wh0 = wr_hi;
        pal = 1'b0;
        wait_write_addr(6'd4, 100);
        cfg.cfg_waitrequest = 1'b1;
        hold_ok = 1'b1;
        repeat (5) begin
            tick();
            if (!(cfg.cfg_write && cfg.cfg_address == 6'd4 && cfg.cfg_data == 32'h0000_0404))
                hold_ok = 1'b0;
        end
        check("t2_hold", 32'(hold_ok), 32'd1);
        cfg.cfg_waitrequest = 1'b0;
        tick();
        check("t2_gap_after_accept", 32'(cfg.cfg_write), 32'd0);
        wait_busy_low(500, cyc);
        check("t2_wr_cycles", 32'(wr_hi - wh0), 32'd11);
        check_writes(1'b0, 1, "t2");

        // 3: lock never arrives -> three full sequences then error
        pll_locked = 1'b0;
        repeat (3) tick();
        pal = 1'b1;
        repeat (3) tick();
        check("t3_busy_start", 32'(busy), 32'd1);
        wait_busy_low(2000, cyc);
        check("t3_busy_len", 32'(cyc), 32'(3 * (12 + SETTLE_C + TIMEOUT_C)));
        check("t3_err", 32'(error), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_tvr", 32'(tv_reset), 32'd0);
        check_writes(1'b1, 3, "t3");
        repeat (60) tick();
        check("t3_no_restart_busy", 32'(busy), 32'd0);
        check("t3_err_sticky", 32'(error), 32'd1);
        check_writes(1'b1, 0, "t3_no_restart");

        // 4a: lock rising mid-LOCKWAIT -> IDLE exactly 3 edges later; error cleared at start
        pal = 1'b0;
        repeat (3) tick();
        check("t4a_err_cleared", 32'(error), 32'd0);
        repeat (12 + SETTLE_C + 10) tick();
        check("t4a_busy_in_lockwait", 32'(busy), 32'd1);
        pll_locked = 1'b1;
        tick(); tick();
        check("t4a_busy_e2", 32'(busy), 32'd1);
        tick();
        check("t4a_busy_e3", 32'(busy), 32'd0);
        check_writes(1'b0, 1, "t4a");

        // 4b: pal toggles back during write idx 1 of a PAL sequence
        pal = 1'b1;
        wait_write_addr(6'd3, 100);
        pal = 1'b0;
        wait_busy_low(500, cyc);
        check_writes(1'b1, 1, "t4b_pal");
        low = 0;
        while (!busy && low < 20) begin
            tick();
            low++;
        end
        check("t4b_idle_cycles", 32'(low), 32'd1);
        wait_busy_low(500, cyc);
        check_writes(1'b0, 1, "t4b_ntsc");

        // 5: reset while a write is stalled
        pal = 1'b1;
        repeat (3) tick();
        check("t5_wr_present", 32'(cfg.cfg_write), 32'd1);
        cfg.cfg_waitrequest = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        pal = 1'b0;
        tick();
        check_all_zero("t5_reset");
        rst = 1'b0;
        cfg.cfg_waitrequest = 1'b0;
        repeat (50) tick();
        check("t5_busy", 32'(busy), 32'd0);
        check_writes(1'b0, 0, "t5");

        // 6: sub-period pal glitches between edges
        repeat (5) begin
            tick();
            #2 pal = 1'b1;
            #2 pal = 1'b0;
        end
        repeat (10) tick();
        check("t6_busy", 32'(busy), 32'd0);
        check_writes(1'b0, 0, "t6");

        // Randomized: random standard selections with random stalls
        model_std = 1'b0;
        rnd_mode = 1'b1;
        for (int it = 0; it < 24; it++) begin
            nv = 1'($urandom_range(0, 1));
            pal = nv;
            repeat (5) tick();
            wait_busy_low(2000, cyc);
            check_writes(nv, (nv != model_std) ? 1 : 0, $sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_err", it), 32'(error), 32'd0);
            model_std = nv;
        end
        rnd_mode = 1'b0;
        cfg.cfg_waitrequest = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
